// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a 16-bit bus, with a per-beat watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise data has fixed priority.

`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [`RW-1:0]      i_i_addr,
  input  logic                i_i_req,
  output logic [`I_SIZE-1:0]  o_i_data,
  output logic                o_i_ack,
  input  logic [`RW-1:0]      i_d_addr,
  input  logic [`RW-1:0]      i_d_wdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  output logic [`RW-1:0]      o_d_rdata,
  output logic                o_d_ack,
  output logic [`RW:0]        o_bus_adr,
  output logic [`RW-1:0]      o_bus_dat,
  output logic                o_bus_cyc,
  output logic                o_bus_stb,
  output logic                o_bus_we,
  output logic                o_bus_ispace,
  input  logic [`RW-1:0]      i_bus_dat,
  input  logic                i_bus_ack,
  output logic                o_timeout
);

  typedef enum logic [2:0] {IDLE, D_ACC, I_LO, I_HI, RESP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic [7:0]         wd_cnt, wd_cnt_nxt;
  logic               resp_fetch, resp_fetch_nxt;
  logic               resp_to, resp_to_nxt;
  logic [`I_SIZE-1:0] i_data_nxt;
  logic [`RW-1:0]     d_rdata_nxt;
  logic [`RW-1:0]     beat_data;
  logic               in_beat, wd_expired, beat_end;
  logic               grant_d, grant_i;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      wd_cnt     <= '0;
      resp_fetch <= 1'b0;
      resp_to    <= 1'b0;
      o_i_data   <= '0;
      o_d_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      wd_cnt     <= wd_cnt_nxt;
      resp_fetch <= resp_fetch_nxt;
      resp_to    <= resp_to_nxt;
      o_i_data   <= i_data_nxt;
      o_d_rdata  <= d_rdata_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = data was granted last, 1 = fetch was granted last
  logic last_grant;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && (i_d_req || i_i_req)) begin
      last_grant <= grant_i;
    end
  end

  assign grant_d = i_d_req && (!i_i_req || last_grant);
`else
  assign grant_d = i_d_req;
`endif
  assign grant_i = i_i_req && !grant_d;

  // A beat ends on ack, or when the watchdog would reach its limit this cycle.
  always_comb begin
    in_beat    = (state == D_ACC) || (state == I_LO) || (state == I_HI);
    wd_expired = in_beat && !i_bus_ack && (wd_cnt == WD_LAST);
    beat_end   = in_beat && (i_bus_ack || wd_expired);
    beat_data  = i_bus_ack ? i_bus_dat : '0;
  end

  always_comb begin
    state_nxt      = state;
    wd_cnt_nxt     = wd_cnt;
    resp_fetch_nxt = resp_fetch;
    resp_to_nxt    = resp_to;
    i_data_nxt     = o_i_data;
    d_rdata_nxt    = o_d_rdata;
    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (grant_d)      state_nxt = D_ACC;
        else if (grant_i) state_nxt = I_LO;
      end
      D_ACC: begin
        if (beat_end) begin
          state_nxt      = RESP;
          resp_fetch_nxt = 1'b0;
          resp_to_nxt    = wd_expired;
          if (!i_d_we) d_rdata_nxt = beat_data;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      I_LO: begin
        if (beat_end) begin
          i_data_nxt[`RW-1:0] = beat_data;
          resp_fetch_nxt      = 1'b1;
          resp_to_nxt         = wd_expired;
          wd_cnt_nxt          = '0;
          state_nxt           = wd_expired ? RESP : I_HI;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      I_HI: begin
        if (beat_end) begin
          i_data_nxt[`I_SIZE-1:`RW] = beat_data;
          resp_to_nxt               = wd_expired;
          state_nxt                 = RESP;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus signals are decoded from the state so an async reset drops the strobe at once.
  always_comb begin
    o_bus_adr    = '0;
    o_bus_dat    = '0;
    o_bus_cyc    = 1'b0;
    o_bus_stb    = 1'b0;
    o_bus_we     = 1'b0;
    o_bus_ispace = 1'b0;
    o_i_ack      = 1'b0;
    o_d_ack      = 1'b0;
    o_timeout    = 1'b0;
    case (state)
      D_ACC: begin
        o_bus_adr = {1'b0, i_d_addr};
        o_bus_dat = i_d_wdata;
        o_bus_we  = i_d_we;
        o_bus_cyc = 1'b1;
        o_bus_stb = 1'b1;
      end
      I_LO: begin
        o_bus_adr    = {i_i_addr, 1'b0};
        o_bus_ispace = 1'b1;
        o_bus_cyc    = 1'b1;
        o_bus_stb    = 1'b1;
      end
      I_HI: begin
        o_bus_adr    = {i_i_addr, 1'b1};
        o_bus_ispace = 1'b1;
        o_bus_cyc    = 1'b1;
        o_bus_stb    = 1'b1;
      end
      RESP: begin
        o_i_ack   = resp_fetch;
        o_d_ack   = !resp_fetch;
        o_timeout = resp_to;
      end
      default: ;
    endcase
  end

endmodule
